// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared constants and types for the DA bit-plane serializer
package da_pkg;
    localparam int DA_NX    = 4;
    localparam int DA_XW    = 8;
    localparam int DA_IDX_W = $clog2(DA_XW);

    typedef logic [DA_NX-1:0]       da_slice_t;
    typedef logic [DA_NX*DA_XW-1:0] da_vec_t;
endpackage

// File: rtl/da_bitplane_serializer_if.sv
// rtl/da_bitplane_serializer_if.sv - vector-in / bit-plane-out handshake bundle
interface da_bitplane_serializer_if import da_pkg::*; #(
    parameter int NX = DA_NX,
    parameter int XW = DA_XW
) ();
    localparam int IDX_W = $clog2(XW);

    logic                 in_valid;
    logic                 in_ready;
    logic [NX*XW-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [NX-1:0]        out_slice;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_first;
    logic                 out_last;
    logic                 out_sign;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_slice, out_idx, out_first, out_last, out_sign
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_slice, out_idx, out_first, out_last, out_sign
    );
endinterface

// File: rtl/da_pingpong_buf.sv
// rtl/da_pingpong_buf.sv - two-entry active/hold vector buffer with pop on last slice
module da_pingpong_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_act_data,
    output logic         o_act_full,
    output logic         o_hold_full
);
    logic [W-1:0] r_act_data;
    logic [W-1:0] r_hold_data;
    logic         r_act_full;
    logic         r_hold_full;
    logic         w_accept;

    assign o_ready     = !r_hold_full && !rst;
    assign w_accept    = i_valid && o_ready;
    assign o_act_data  = r_act_data;
    assign o_act_full  = r_act_full;
    assign o_hold_full = r_hold_full;

    // A pop with hold full cannot coincide with an accept, since o_ready is low then.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_full  <= 1'b0;
            r_hold_full <= 1'b0;
            r_act_data  <= '0;
            r_hold_data <= '0;
        end else if (i_pop) begin
            if (r_hold_full) begin
                r_act_data  <= r_hold_data;
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_act_data <= i_data;
            end else begin
                r_act_full <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_act_full) begin
                r_act_data <= i_data;
                r_act_full <= 1'b1;
            end else begin
                r_hold_data <= i_data;
                r_hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/da_bitplane_serializer.sv
// rtl/da_bitplane_serializer.sv - DA bit-plane serializer top; DA_MSB_FIRST_EN selects MSB-first plane order
module da_bitplane_serializer import da_pkg::*; #(
    parameter int NX = DA_NX,
    parameter int XW = DA_XW
) (
    input  logic                    clk,
    input  logic                    rst,
    da_bitplane_serializer_if.slave bus,
    output logic                    busy
);
    localparam int                 IDX_W   = $clog2(XW);
    localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(XW-1);
`ifdef DA_MSB_FIRST_EN
    localparam logic [IDX_W-1:0]   IDX_START = IDX_MAX;
    localparam logic [IDX_W-1:0]   IDX_END   = '0;
`else
    localparam logic [IDX_W-1:0]   IDX_START = '0;
    localparam logic [IDX_W-1:0]   IDX_END   = IDX_MAX;
`endif

    logic [IDX_W-1:0] r_idx;
    logic [NX*XW-1:0] w_act_data;
    logic             w_act_full;
    logic             w_hold_full;
    logic             w_adv;
    logic             w_pop;
    logic [NX-1:0]    w_slice;
    logic [XW-1:0]    w_samp [NX];

    assign w_adv = w_act_full && bus.out_ready;
    assign w_pop = w_adv && (r_idx == IDX_END);

    da_pingpong_buf #(.W(NX*XW)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (bus.in_valid),
        .o_ready     (bus.in_ready),
        .i_data      (bus.in_data),
        .i_pop       (w_pop),
        .o_act_data  (w_act_data),
        .o_act_full  (w_act_full),
        .o_hold_full (w_hold_full)
    );

    // The counter wraps to the start plane on the final slice, so a newly loaded vector always begins there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= IDX_START;
        end else if (w_adv) begin
            if (r_idx == IDX_END) begin
                r_idx <= IDX_START;
            end else begin
`ifdef DA_MSB_FIRST_EN
                r_idx <= r_idx - IDX_W'(1);
`else
                r_idx <= r_idx + IDX_W'(1);
`endif
            end
        end
    end

    for (genvar g = 0; g < NX; g++) begin : g_samp
        assign w_samp[g] = w_act_data[g*XW +: XW];
    end

    always_comb begin
        w_slice = '0;
        for (int k = 0; k < NX; k++) begin
            w_slice[k] = w_samp[k][r_idx];
        end
    end

    // Outputs are qualified by act_full so an idle or freshly reset block presents all zeros.
    assign bus.out_valid = w_act_full;
    assign bus.out_slice = w_act_full ? w_slice : '0;
    assign bus.out_idx   = w_act_full ? r_idx : '0;
    assign bus.out_first = w_act_full && (r_idx == IDX_START);
    assign bus.out_last  = w_act_full && (r_idx == IDX_END);
    assign bus.out_sign  = w_act_full && (r_idx == IDX_MAX);
    assign busy          = w_act_full || w_hold_full;
endmodule

// File: doc/da_bitplane_serializer.md
Name: da_bitplane_serializer

Overview:
- Transmit-side feeder for the bit-serial distributed-arithmetic (DA) dot-product engine.
- Accepts one parallel vector of NX signed XW-bit samples per handshake.
- Emits one NX-bit bit-plane slice per cycle: bit k of the slice is bit idx of sample x_k, LSB plane first by default.
- A two-entry ping-pong buffer lets back-to-back vectors stream with no bubble between the sign plane of one vector and plane 0 of the next.

Parameters:
- NX, 4, number of samples per vector (DA LUT address width).
- XW, 8, sample width in bits (planes per vector); minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid vector.
- in_ready  output  1  block can accept a vector this cycle.
- in_data  input  NX*XW  packed samples; x0 in bits [XW-1:0], x_k in bits [k*XW+XW-1:k*XW].
- out_valid  output  1  out_slice is valid.
- out_ready  input  1  downstream consumes the slice this cycle.
- out_slice  output  NX  bit-plane; out_slice[k] = x_k[out_idx].
- out_idx  output  $clog2(XW)  plane index of current slice.
- out_first  output  1  first slice of a vector.
- out_last  output  1  final slice of a vector.
- out_sign  output  1  current plane is the sign plane (idx XW-1); downstream subtracts this plane.
- busy  output  1  active or hold entry occupied.

Behaviour:
- Single clock; reset is synchronous and active-high on rst. All state is updated only on rising clk.
- Storage: active entry (vector being sliced, plus plane counter) and hold entry (next vector). Flags act_full and hold_full.
- Reset values: out_valid=0, out_first=0, out_last=0, out_sign=0, out_slice=0, out_idx=0, busy=0, both flags 0.
- in_ready = !hold_full && !rst. It is combinational from registered state only and never depends on in_valid.
- Accept when in_valid && in_ready:
  - Vector goes to active if act_full=0, or if the active entry's last slice is consumed in the same cycle with hold_full=0.
  - Otherwise it goes to hold.
- Latency: a vector accepted in cycle t with an idle engine produces out_valid=1 with plane 0 at t+1.
- Output:
  - out_valid = act_full.
  - The slice advances only on out_valid && out_ready.
  - While stalled, all out_* signals hold stable.
- Plane counter: runs 0..XW-1 and wraps to 0 on the final slice.
  - out_first = (idx==0).
  - out_last = (idx==XW-1).
  - out_sign = (idx==XW-1).
- Completion: when the last slice is consumed:
  - If hold_full, hold moves to active in the same cycle, so plane 0 of the next vector is valid the very next cycle. hold_full clears, and in_ready rises the following cycle.
  - Else, if an input is accepted that same cycle, it loads directly into active.
  - Else act_full clears.
- Throughput: one vector per XW consumed cycles, sustained.
- Simultaneous accept and completion never drops or duplicates a vector.
- Reset mid-vector: both entries are discarded, the partial vector is lost, and the output returns to its reset values the next cycle.
- Samples are passed through unmodified; sign handling is the consumer's job, flagged by out_sign.
- busy = act_full || hold_full.

Optional Feature:
- Macro DA_MSB_FIRST_EN.
- When defined:
  - Planes are emitted XW-1 down to 0.
  - out_first and out_sign are asserted on the idx XW-1 plane; out_last is asserted on the idx 0 plane.
  - For consumers using a left-shift (Horner) accumulator.
- When undefined: LSB-first ordering as above, with out_sign coinciding with out_last.
- Handshake and latency are identical in both modes.

Decomposition:
- Package da_pkg holds:
  - constants DA_NX=4, DA_XW=8, DA_IDX_W=$clog2(DA_XW);
  - typedef da_slice_t (logic [DA_NX-1:0]);
  - typedef da_vec_t (logic [DA_NX*DA_XW-1:0]).
- One natural sub-module, da_pingpong_buf: the two-entry buffer with valid/ready in and pop/out. It owns act_full and hold_full.
- Plane counter and slice muxing live in the top module.

Test Plan:
- Single vector, LSB mode: x0=0x01, x1=0x80, x2=0xFF, x3=0x00 accepted at t.
  - Slices from t+1, out_ready=1: idx0=0x5 with first=1; idx1..6=0x4; idx7=0x6 with last=1, sign=1. out_valid drops at t+9.
- Back-to-back: three vectors offered continuously with out_ready=1.
  - 24 consecutive valid slices, no bubble.
  - in_ready low exactly while hold is full.
  - out_first at cycles 1, 9 and 17.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly.
  - out_slice, out_idx and the flags stay stable during stalls.
  - All 8 planes of 0xA5/0x5A/0x00/0xFF are delivered in order.
- Simultaneous: hold empty, in_valid=1 in the same cycle the last slice is consumed.
  - New vector's plane 0 appears the next cycle.
  - in_ready stays 1.
- Reset mid-vector: rst pulsed at plane 3.
  - Next cycle out_valid=0 and busy=0.
  - The next accepted vector starts at idx0 with first=1.
- DA_MSB_FIRST_EN defined, same vector as the first scenario:
  - First slice is idx7=0x6 with first=1 and sign=1.
  - Last slice is idx0=0x5 with last=1.
